// File: rtl/seq_gen.sv
// seq_gen: repeats a fixed bit pattern reps times, with idle gaps between repetitions.
// Defining SEQ_GEN_PARITY_EN appends an even-parity bit to each repetition.
module seq_gen #(
    parameter int             PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1110,
    parameter int             GAP_LEN = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] reps,
    output logic       sout,
    output logic       sout_vld,
    output logic       busy,
    output logic       done
);
    localparam int IW = $clog2(PAT_W);
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] SEND = 3'd1;
    localparam logic [2:0] GAP  = 3'd2;
`ifdef SEQ_GEN_PARITY_EN
    localparam logic [2:0] PAR  = 3'd3;
`endif
    localparam logic [2:0] DONE = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [IW-1:0] idx_q, idx_d, idx_m1;
    logic [3:0]    reps_q, reps_d, rem;
    logic [3:0]    gap_q, gap_d;
    logic          sout_q, sout_d, vld_q, vld_d, busy_q, busy_d, done_q, done_d;
    logic          end_rep, load;

    assign idx_m1 = idx_q - 1'b1;

`ifdef SEQ_GEN_PARITY_EN
    // reps was already decremented on leaving bit 0, so PAR decides on it as-is
    assign end_rep = state_q == PAR;
    assign rem     = reps_q;
`else
    assign end_rep = state_q == SEND && idx_q == '0;
    assign rem     = reps_q - 4'd1;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        reps_d  = reps_q;
        gap_d   = gap_q;
        sout_d  = 1'b0;
        vld_d   = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        load    = 1'b0;
        case (state_q)
            IDLE: if (start && reps != 4'd0) begin
                reps_d = reps;
                load   = 1'b1;
            end
            SEND: if (idx_q != '0) begin
                idx_d  = idx_m1;
                sout_d = PATTERN[idx_m1];
                vld_d  = 1'b1;
                busy_d = 1'b1;
            end
`ifdef SEQ_GEN_PARITY_EN
            else begin
                state_d = PAR;
                reps_d  = reps_q - 4'd1;
                sout_d  = ^PATTERN;
                vld_d   = 1'b1;
                busy_d  = 1'b1;
            end
            PAR: ;
`endif
            GAP: begin
                busy_d = 1'b1;
                if (gap_q == 4'd0) load = 1'b1;
                else gap_d = gap_q - 4'd1;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (end_rep) begin
            reps_d = rem;
            if (rem == 4'd0) begin
                state_d = DONE;
                done_d  = 1'b1;
            end else if (GAP_LEN != 0) begin
                state_d = GAP;
                gap_d   = 4'(GAP_LEN - 1);
                busy_d  = 1'b1;
            end else begin
                load = 1'b1;
            end
        end
        if (load) begin
            state_d = SEND;
            idx_d   = IW'(PAT_W - 1);
            sout_d  = PATTERN[PAT_W-1];
            vld_d   = 1'b1;
            busy_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            reps_q  <= '0;
            gap_q   <= '0;
            sout_q  <= 1'b0;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            reps_q  <= reps_d;
            gap_q   <= gap_d;
            sout_q  <= sout_d;
            vld_q   <= vld_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign sout     = sout_q;
    assign sout_vld = vld_q;
    assign busy     = busy_q;
    assign done     = done_q;
endmodule

// File: tb/tb_seq_gen.sv
// tb_seq_gen: drives two seq_gen instances (default and gapless 5-bit) against an arithmetic model.
module tb_seq_gen;
`ifdef SEQ_GEN_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int PW1 = 5;
    localparam logic [15:0] PAT0 = 16'b1110;
    localparam logic [15:0] PAT1 = 16'b10110;

    logic       clk = 1'b0, reset = 1'b1;
    logic       st0 = 1'b0, st1 = 1'b0;
    logic [3:0] rp0 = 4'd0, rp1 = 4'd0;
    logic       so0, v0, b0, d0, so1, v1, b1, d1;
    int         checks = 0, errors = 0;

    always #5 clk = ~clk;

    seq_gen u0 (.clk(clk), .reset(reset), .start(st0), .reps(rp0),
                .sout(so0), .sout_vld(v0), .busy(b0), .done(d0));
    seq_gen #(.PAT_W(PW1), .PATTERN(5'b10110), .GAP_LEN(0)) u1 (
                .clk(clk), .reset(reset), .start(st1), .reps(rp1),
                .sout(so1), .sout_vld(v1), .busy(b1), .done(d1));

    function automatic int blen(int pw, int gl, int r);
        return r == 0 ? -1 : r * (pw + P) + (r - 1) * gl;
    endfunction

    // expected {sout, sout_vld, busy, done} at t cycles after start acceptance
    function automatic logic [3:0] expv(int pw, logic [15:0] pat, int gl, int r, int t);
        int l, b, pos;
        l = pw + P;
        b = blen(pw, gl, r);
        if (r == 0 || t > b) return 4'b0000;
        if (t == b) return 4'b0001;
        pos = t % (l + gl);
        if (pos < pw) return {pat[pw-1-pos], 3'b110};
        if (pos < l) return {^pat, 3'b110};
        return 4'b0010;
    endfunction

    task automatic check_idle(input string name);
        checks += 2;
        if ({so0, v0, b0, d0} !== 4'b0000) begin
            errors++;
            $display("FAIL %s u0: got %b expected 0000", name, {so0, v0, b0, d0});
        end
        if ({so1, v1, b1, d1} !== 4'b0000) begin
            errors++;
            $display("FAIL %s u1: got %b expected 0000", name, {so1, v1, b1, d1});
        end
    endtask

    task automatic run(input string name, input int r0, input int r1, input bit hold, input int abort_t);
        int bl0, bl1, n;
        logic [3:0] e0, e1;
        bl0 = blen(4, 1, r0);
        bl1 = blen(PW1, 0, r1);
        n = (bl0 > bl1 ? bl0 : bl1) + 4;
        @(negedge clk);
        st0 = 1'b1; st1 = 1'b1; rp0 = 4'(r0); rp1 = 4'(r1);
        for (int t = 0; t < n; t++) begin
            @(negedge clk);
            e0 = expv(4, PAT0, 1, r0, t);
            e1 = expv(PW1, PAT1, 0, r1, t);
            checks += 2;
            if ({so0, v0, b0, d0} !== e0) begin
                errors++;
                $display("FAIL %s u0 t=%0d: got %b expected %b", name, t, {so0, v0, b0, d0}, e0);
            end
            if ({so1, v1, b1, d1} !== e1) begin
                errors++;
                $display("FAIL %s u1 t=%0d: got %b expected %b", name, t, {so1, v1, b1, d1}, e1);
            end
            if (t == abort_t) begin
                reset = 1'b1;
                #1;
                check_idle({name, "_async"});
                break;
            end
            st0 = hold && t < bl0;
            st1 = hold && t < bl1;
            rp0 = 4'($urandom_range(0, 15));
            rp1 = 4'($urandom_range(0, 15));
        end
        st0 = 1'b0; st1 = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        check_idle("reset_async");
        @(negedge clk);
        @(negedge clk);
        check_idle("reset_held");
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_idle("reset_release");
        end
    endtask

    task automatic test_single();
        run("single", 1, 1, 1'b0, -1);
    endtask

    task automatic test_multi();
        run("multi", 3, 3, 1'b0, -1);
        run("mixed", 2, 0, 1'b0, -1);
    endtask

    task automatic test_reps_zero();
        run("reps_zero", 0, 0, 1'b0, -1);
    endtask

    task automatic test_hold_start();
        run("hold_start", 2, 2, 1'b1, -1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_idle("hold_after");
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++)
            run("random", $urandom_range(1, 15), $urandom_range(1, 15), 1'($urandom_range(0, 1)), -1);
    endtask

    task automatic test_reset_mid();
        run("reset_mid", 2, 2, 1'b0, 4 + P + 2);
        @(negedge clk);
        check_idle("reset_mid_held");
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_idle("reset_mid_nodone");
        end
        run("after_reset", 1, 1, 1'b0, -1);
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_reps_zero();
        test_hold_start();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/seq_gen.md
SEQ_GEN -- requirements
Module: seq_gen

Interface
REQ-001 Parameter: PAT_W, default 4, pattern length in bits (legal 2..16).
REQ-002 Parameter: PATTERN, default 4'b1110, bit pattern transmitted MSB first.
REQ-003 Parameter: GAP_LEN, default 1, idle bit-times between consecutive repetitions (legal 0..15).
REQ-004 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-005 Port: reset  input  1  asynchronous, active-high reset.
REQ-006 Port: start  input  1  request to begin a burst; sampled only in IDLE.
REQ-007 Port: reps  input  4  number of pattern repetitions in the burst; latched when start is accepted.
REQ-008 Port: sout  output  1  serial data bit, one bit per clock.
REQ-009 Port: sout_vld  output  1  high on every cycle in which sout carries a pattern bit or parity bit.
REQ-010 Port: busy  output  1  high from start acceptance until the last transmitted bit-time or gap cycle completes.
REQ-011 Port: done  output  1  single-cycle pulse marking burst completion.

Function
REQ-012 All outputs SHALL be registered; no combinational path from start or reps to any output.
REQ-013 FSM states SHALL be IDLE, SEND, GAP, PAR (parity build only), and DONE.
REQ-014 IDLE: sout=0, sout_vld=0, busy=0, done=0.
REQ-015 Start acceptance: start=1 and reps!=0 at a clock edge in IDLE latches reps and enters SEND. The same edge SHALL drive sout=PATTERN[PAT_W-1], sout_vld=1, and busy=1.
REQ-016 start=1 with reps=0 SHALL be ignored (remain IDLE, no done).
REQ-017 SEND: each cycle emits the next lower pattern bit with sout_vld=1; a down-counting bit index runs from PAT_W-1 to 0.
REQ-018 End of pattern (index 0): the remaining-reps counter SHALL decrement by 1.
REQ-019 If remaining reps>0 and GAP_LEN>0, go to GAP. If remaining reps>0 and GAP_LEN=0, restart SEND back-to-back with no idle cycle. If remaining reps=0, go to DONE.
REQ-020 GAP: exactly GAP_LEN cycles with sout=0, sout_vld=0, busy=1; then SEND from MSB.
REQ-021 DONE: done=1 for exactly one cycle; busy=0, sout=0, sout_vld=0 in that cycle; then IDLE.
REQ-022 Busy duration (cycles) SHALL equal reps*(PAT_W+P) + (reps-1)*GAP_LEN, where P=1 if parity is compiled in, else 0.
REQ-023 start asserted during SEND, GAP, PAR or DONE SHALL be ignored and SHALL NOT be queued; a new burst needs start in IDLE.
REQ-024 Changes on reps after acceptance SHALL NOT affect the burst in progress.

Reset
REQ-025 reset=1 SHALL immediately force state IDLE and set sout=0, sout_vld=0, busy=0, done=0, with bit index and reps counter cleared.
REQ-026 Reset during a burst SHALL abandon it with no done pulse; the first accepted start after reset release behaves per REQ-015.

Configuration
REQ-027 Macro: SEQ_GEN_PARITY_EN.
REQ-028 Defined: after bit 0 of each repetition, state PAR emits one even-parity bit over PATTERN (sout=^PATTERN, sout_vld=1) before the REQ-019 decision.
REQ-029 Undefined: the PAR state and parity logic SHALL be absent, and each repetition is exactly PAT_W bits.

Verification
REQ-030 Defaults, reps=1, start pulse -> sout 1,1,1,0 with sout_vld=1 for 4 cycles, then done pulse; busy high for 4 cycles.
REQ-031 Defaults, reps=3 -> bursts 1110,0(gap),1110,0(gap),1110; busy=14 cycles; a downstream 1110 non-overlapping detector fires exactly 3 times.
REQ-032 GAP_LEN=0, reps=2 -> 11101110 contiguous with sout_vld continuously high for 8 cycles, then done.
REQ-033 Parity build, defaults, reps=2 -> 1110 1, gap 0, 1110 1; busy=11 cycles.
REQ-034 start held high throughout a reps=2 burst -> only one burst, no second burst queued. reps=0 start -> no activity.
REQ-035 reset asserted on the 2nd bit of the 2nd repetition -> all outputs 0 asynchronously, no done. A subsequent start with reps=1 -> clean 1110.
